// File: rtl/register_read.sv
// register_read
//   Decode-stage operand fetch for the MIPS core.
//   The rs/rt operands come from the architectural register array. A write-back
//   in the same cycle is forwarded, and $zero always reads as 0. The operands are
//   then held in a 1-entry valid/ready pipeline register for execute.
//
// Ports
//   clk, rst_n                 rising-edge clock, asynchronous active-low reset
//   register                   architectural register array (NREG x DATA_W)
//   rs_number, rt_number       source register indices from decode
//   in_valid / in_ready        decode handshake
//   wb_number, wb_data,
//   wb_reg_write               write-back port (bypass / stall coherence)
//   flush                      kill the held instruction
//   rs_data, rt_data           held operands to execute
//   rs_idx, rt_idx             held source indices
//   out_valid / out_ready      execute handshake
module register_read #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] register [NREG-1:0],
  input  logic [ADDR_W-1:0] rs_number,
  input  logic [ADDR_W-1:0] rt_number,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] wb_number,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_reg_write,
  input  logic              flush,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [ADDR_W-1:0] rs_idx,
  output logic [ADDR_W-1:0] rt_idx,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   rs_data_reg, rs_data_next;
  logic [DATA_W-1:0]   rt_data_reg, rt_data_next;
  logic [ADDR_W-1:0]   rs_idx_reg, rs_idx_next;
  logic [ADDR_W-1:0]   rt_idx_reg, rt_idx_next;

  logic                accept;
  logic                stall;

  // Fetch path, one instance per source port (0 = rs, 1 = rt).
  logic [ADDR_W-1:0]   src_idx [2];
  logic [DATA_W-1:0]   src_val [2];

  assign src_idx[0] = rs_number;
  assign src_idx[1] = rt_number;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fetch
      // $zero wins over the bypass, the bypass wins over the array.
      assign src_val[gi] = (src_idx[gi] == '0) ? '0 :
                           (wb_reg_write && (wb_number == src_idx[gi])) ? wb_data :
                           register[src_idx[gi]];
    end
  endgenerate

  assign out_valid = (state_reg == FULL);
  assign in_ready  = !flush && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign stall     = out_valid && !out_ready;

  always_comb begin
    state_next   = state_reg;
    rs_data_next = rs_data_reg;
    rt_data_next = rt_data_reg;
    rs_idx_next  = rs_idx_reg;
    rt_idx_next  = rt_idx_reg;

    if (flush) begin
      state_next = EMPTY;
    end else if (accept) begin
      state_next = FULL;
    end else if (out_valid && out_ready) begin
      state_next = EMPTY;
    end

    if (accept) begin
      rs_data_next = src_val[0];
      rt_data_next = src_val[1];
      rs_idx_next  = rs_number;
      rt_idx_next  = rt_number;
    end else if (stall) begin
      // Keep the held operands coherent with write-backs that land while
      // execute is not taking them; $zero is never overwritten.
      if (wb_reg_write && (wb_number == rs_idx_reg) && (rs_idx_reg != '0))
        rs_data_next = wb_data;
      if (wb_reg_write && (wb_number == rt_idx_reg) && (rt_idx_reg != '0))
        rt_data_next = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= EMPTY;
      rs_data_reg <= '0;
      rt_data_reg <= '0;
      rs_idx_reg  <= '0;
      rt_idx_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      rs_data_reg <= rs_data_next;
      rt_data_reg <= rt_data_next;
      rs_idx_reg  <= rs_idx_next;
      rt_idx_reg  <= rt_idx_next;
    end
  end

  assign rs_data = rs_data_reg;
  assign rt_data = rt_data_reg;
  assign rs_idx  = rs_idx_reg;
  assign rt_idx  = rt_idx_reg;

endmodule

// File: tb/tb_register_read.sv
// tb_register_read
//   Scoreboard bench for register_read. The stimulus process pushes the
//   expected operands of every instruction that will reach execute. A monitor
//   pops one entry on every transfer and compares it. Handshake and reset
//   behaviour are checked directly in the stimulus.
module tb_register_read;

  typedef struct packed {
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] regs [31:0];
  logic [4:0]  rs_number, rt_number;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  wb_number;
  logic [31:0] wb_data;
  logic        wb_reg_write;
  logic        flush;
  logic [31:0] rs_data, rt_data;
  logic [4:0]  rs_idx, rt_idx;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;
  exp_t sb [$];

  register_read dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .register     (regs),
    .rs_number    (rs_number),
    .rt_number    (rt_number),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .wb_number    (wb_number),
    .wb_data      (wb_data),
    .wb_reg_write (wb_reg_write),
    .flush        (flush),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .rs_idx       (rs_idx),
    .rt_idx       (rt_idx),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt);
    in_valid  = 1'b1;
    rs_number = rs;
    rt_number = rt;
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] ra, input logic [4:0] rb);
    exp_t e;
    e.rs_data = a;
    e.rt_data = b;
    e.rs_idx  = ra;
    e.rt_idx  = rb;
    return e;
  endfunction

  // Monitor: every transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_transfer: got rs=%0d rt=%0d, expected none", rs_idx, rt_idx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("xfer_rs_data", rs_data, e.rs_data);
        chk("xfer_rt_data", rt_data, e.rt_data);
        chk("xfer_rs_idx", {27'd0, rs_idx}, {27'd0, e.rs_idx});
        chk("xfer_rt_idx", {27'd0, rt_idx}, {27'd0, e.rt_idx});
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0101 * i;
    regs[3] = 32'h11;
    regs[4] = 32'h22;
    regs[5] = 32'hAAAA;
    regs[7] = 32'h7777;
    rst_n = 1'b0;
    rs_number = '0; rt_number = '0; in_valid = 1'b0;
    wb_number = '0; wb_data = '0; wb_reg_write = 1'b0;
    flush = 1'b0; out_ready = 1'b0;

    @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_rs_data", rs_data, 32'd0);
    chk("reset_rt_data", rt_data, 32'd0);
    tick();
    rst_n = 1'b1;

    // Plain fetch.
    out_ready = 1'b1;
    issue(5'd3, 5'd4);
    sb.push_back(mk(32'h11, 32'h22, 5'd3, 5'd4));
    tick();
    // Same-cycle write-back bypass on both ports.
    issue(5'd5, 5'd5);
    wb_reg_write = 1'b1; wb_number = 5'd5; wb_data = 32'h1234;
    sb.push_back(mk(32'h1234, 32'h1234, 5'd5, 5'd5));
    @(negedge clk);
    chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    tick();
    // $zero ignores a write-back aimed at it.
    issue(5'd0, 5'd3);
    wb_number = 5'd0; wb_data = 32'hFFFF_FFFF;
    sb.push_back(mk(32'h0, 32'h11, 5'd0, 5'd3));
    tick();

    // Four back-to-back; the first one has a disabled write-back matching rs.
    wb_reg_write = 1'b0; wb_number = 5'd1; wb_data = 32'hDEAD_BEEF;
    issue(5'd1, 5'd2);
    sb.push_back(mk(32'h0101, 32'h0202, 5'd1, 5'd2));
    tick();
    issue(5'd6, 5'd8);
    sb.push_back(mk(32'h0606, 32'h0808, 5'd6, 5'd8));
    @(negedge clk);
    chk("b2b_out_valid_1", {31'd0, out_valid}, 32'd1);
    tick();
    issue(5'd9, 5'd10);
    sb.push_back(mk(32'h0909, 32'h0A0A, 5'd9, 5'd10));
    @(negedge clk);
    chk("b2b_out_valid_2", {31'd0, out_valid}, 32'd1);
    tick();
    issue(5'd31, 5'd30);
    sb.push_back(mk(32'h1F1F, 32'h1E1E, 5'd31, 5'd30));
    @(negedge clk);
    chk("b2b_out_valid_3", {31'd0, out_valid}, 32'd1);
    tick();

    // Stall with a write-back to the held rt in the second cycle.
    issue(5'd2, 5'd7);
    sb.push_back(mk(32'h0202, 32'hBEEF, 5'd2, 5'd7));
    @(negedge clk);
    chk("b2b_out_valid_4", {31'd0, out_valid}, 32'd1);
    tick();
    out_ready = 1'b0;
    issue(5'd1, 5'd1);
    @(negedge clk);
    chk("stall1_in_ready", {31'd0, in_ready}, 32'd0);
    chk("stall1_rt_data", rt_data, 32'h7777);
    tick();
    wb_reg_write = 1'b1; wb_number = 5'd7; wb_data = 32'hBEEF;
    @(negedge clk);
    chk("stall2_in_ready", {31'd0, in_ready}, 32'd0);
    chk("stall2_out_valid", {31'd0, out_valid}, 32'd1);
    tick();
    wb_reg_write = 1'b0;
    @(negedge clk);
    chk("stall3_rt_data", rt_data, 32'hBEEF);
    chk("stall3_rs_data", rs_data, 32'h0202);
    chk("stall3_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();

    // Flush while full and stalled; the flushed instruction never transfers.
    issue(5'd3, 5'd4);
    tick();
    out_ready = 1'b0;
    flush = 1'b1;
    issue(5'd5, 5'd5);
    @(negedge clk);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    tick();

    // Asynchronous reset while full.
    issue(5'd9, 5'd10);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("prereset_out_valid", {31'd0, out_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_reset_rs_data", rs_data, 32'd0);
    chk("async_reset_rt_data", rt_data, 32'd0);
    chk("async_reset_rt_idx", {27'd0, rt_idx}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
